// File: rtl/state_delay_fifo.sv
// state_delay_fifo: elastic buffer carrying State1 vectors from the forward pass to the weight update.
// Define STATE_DELAY_FIFO_COUNT_EN to add the registered occupancy port oCount.
module state_delay_fifo #(
    parameter int unsigned NP    = 8,
    parameter int unsigned WF    = 5,
    parameter int unsigned DEPTH = 4
) (
    input  logic                iCLK,
    input  logic                iRST,
    input  logic                iMode,
    input  logic                iValid_AM_State1,
    output logic                oReady_AM_State1,
    input  logic [NP*WF-1:0]    iData_AM_State1,
    output logic                oValid_BM_State1,
    input  logic                iReady_BM_State1,
    output logic [NP*WF-1:0]    oData_BM_State1
`ifdef STATE_DELAY_FIFO_COUNT_EN
    ,
    output logic [$clog2(DEPTH):0] oCount
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned DW = NP * WF;

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wp_q, wp_d;
    logic [AW:0]   rp_q, rp_d;
    logic          ready_q, ready_d;
    logic          valid_q, valid_d;
    logic          full_q, full_d, empty_d;
    logic          push, pop;

    assign full_q = (wp_q[AW-1:0] == rp_q[AW-1:0]) && (wp_q[AW] != rp_q[AW]);

    // The full term only matters in the cycle where iMode rises while ready still holds
    // the inference constant; it keeps a stored vector from being overwritten.
    assign push = iValid_AM_State1 & ready_q & iMode & ~full_q;
    assign pop  = valid_q & iReady_BM_State1;

    always_comb begin
        wp_d    = wp_q + {{AW{1'b0}}, push};
        rp_d    = rp_q + {{AW{1'b0}}, pop};
        full_d  = (wp_d[AW-1:0] == rp_d[AW-1:0]) && (wp_d[AW] != rp_d[AW]);
        empty_d = (wp_d == rp_d);
        ready_d = iMode ? ~full_d : 1'b1;
        valid_d = iMode & ~empty_d;
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            wp_q    <= '0;
            rp_q    <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    // Payload storage is deliberately left out of reset.
    always_ff @(posedge iCLK) begin
        if (push) begin
            mem[wp_q[AW-1:0]] <= iData_AM_State1;
        end
    end

    assign oReady_AM_State1 = ready_q;
    assign oValid_BM_State1 = valid_q;
    assign oData_BM_State1  = mem[rp_q[AW-1:0]];

`ifdef STATE_DELAY_FIFO_COUNT_EN
    logic [AW:0] count_q;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            count_q <= '0;
        end else begin
            count_q <= wp_d - rp_d;
        end
    end

    assign oCount = count_q;
`endif

endmodule

// File: tb/tb_state_delay_fifo.sv
// Bench for state_delay_fifo: directed vector table, hand sequences and a queue-based random model.
module tb_state_delay_fifo;

    localparam int unsigned NP    = 8;
    localparam int unsigned WF    = 5;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = NP * WF;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          mode;
    logic          vin;
    logic          rin;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          rdy;
    logic          vld;
`ifdef STATE_DELAY_FIFO_COUNT_EN
    logic [CW-1:0] cnt;
`endif

    state_delay_fifo #(
        .NP   (NP),
        .WF   (WF),
        .DEPTH(DEPTH)
    ) dut (
        .iCLK            (clk),
        .iRST            (rst),
        .iMode           (mode),
        .iValid_AM_State1(vin),
        .oReady_AM_State1(rdy),
        .iData_AM_State1 (din),
        .oValid_BM_State1(vld),
        .iReady_BM_State1(rin),
        .oData_BM_State1 (dout)
`ifdef STATE_DELAY_FIFO_COUNT_EN
        ,
        .oCount          (cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: an ordered queue of stored vectors plus the two registered handshakes.
    logic [DW-1:0] q[$];
    bit            m_rdy;
    bit            m_vld;

    typedef struct {
        bit            mode;
        bit            vin;
        logic [DW-1:0] din;
        bit            rin;
        bit            e_rdy;
        bit            e_vld;
        logic [DW-1:0] e_dat;
        int            e_cnt;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(bit m, bit v, logic [DW-1:0] d, bit r,
                                bit er, bit ev, logic [DW-1:0] ed, int ec);
        vec_t t;
        t.mode = m; t.vin = v; t.din = d; t.rin = r;
        t.e_rdy = er; t.e_vld = ev; t.e_dat = ed; t.e_cnt = ec;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_rdy = 1'b0;
        m_vld = 1'b0;
    endtask

    task automatic model_step(input bit m, input bit v, input logic [DW-1:0] d, input bit r);
        bit do_push;
        bit do_pop;
        do_push = v && m_rdy && m && (q.size() < DEPTH);
        do_pop  = m_vld && r;
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(d);
        m_rdy = m ? (q.size() < DEPTH) : 1'b1;
        m_vld = m && (q.size() > 0);
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".ready"}, rdy, m_rdy);
        chk({tag, ".valid"}, vld, m_vld);
        if (m_vld) chk({tag, ".data"}, dout, q[0]);
`ifdef STATE_DELAY_FIFO_COUNT_EN
        chk({tag, ".count"}, cnt, q.size());
`endif
    endtask

    // Called at a falling edge: drive, let one rising edge happen, return at the next falling edge.
    task automatic cyc(input bit m, input bit v, input logic [DW-1:0] d, input bit r);
        mode = m;
        vin  = v;
        din  = d;
        rin  = r;
        @(posedge clk);
        model_step(m, v, d, r);
        @(negedge clk);
    endtask

    initial begin
        logic [DW-1:0] rd;

        // mode, vin, din, rin -> ready, valid, head, count
        tbl[0]  = mk(1, 0, 'h00, 0, 1, 0, 'h00, 0);
        tbl[1]  = mk(1, 1, 'h01, 0, 1, 1, 'h01, 1);
        tbl[2]  = mk(1, 1, 'h02, 0, 1, 1, 'h01, 2);
        tbl[3]  = mk(1, 1, 'h03, 0, 1, 1, 'h01, 3);
        tbl[4]  = mk(1, 1, 'h04, 0, 0, 1, 'h01, 4);
        tbl[5]  = mk(1, 1, 'h05, 0, 0, 1, 'h01, 4);
        tbl[6]  = mk(1, 1, 'h05, 1, 1, 1, 'h02, 3);
        tbl[7]  = mk(1, 1, 'h05, 1, 1, 1, 'h03, 3);
        tbl[8]  = mk(1, 1, 'h06, 1, 1, 1, 'h04, 3);
        tbl[9]  = mk(1, 1, 'h07, 1, 1, 1, 'h05, 3);
        tbl[10] = mk(1, 0, 'h00, 1, 1, 1, 'h06, 2);
        tbl[11] = mk(0, 1, 'h08, 0, 1, 0, 'h00, 2);
        tbl[12] = mk(0, 1, 'h09, 0, 1, 0, 'h00, 2);
        tbl[13] = mk(0, 1, 'h0A, 0, 1, 0, 'h00, 2);
        tbl[14] = mk(1, 0, 'h00, 0, 1, 1, 'h06, 2);
        tbl[15] = mk(1, 0, 'h00, 1, 1, 1, 'h07, 1);
        tbl[16] = mk(1, 0, 'h00, 1, 1, 0, 'h00, 0);

        rst = 1'b1; mode = 1'b1; vin = 1'b0; din = '0; rin = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset.ready", rdy, 1'b0);
        chk("reset.valid", vld, 1'b0);
`ifdef STATE_DELAY_FIFO_COUNT_EN
        chk("reset.count", cnt, 0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].mode, tbl[i].vin, tbl[i].din, tbl[i].rin);
            chk($sformatf("row%0d.ready", i), rdy, tbl[i].e_rdy);
            chk($sformatf("row%0d.valid", i), vld, tbl[i].e_vld);
            if (tbl[i].e_vld) chk($sformatf("row%0d.data", i), dout, tbl[i].e_dat);
`ifdef STATE_DELAY_FIFO_COUNT_EN
            chk($sformatf("row%0d.count", i), cnt, tbl[i].e_cnt);
`endif
        end

        // Streaming with one resident vector: pointers wrap more than twice.
        cyc(1, 1, 'h10, 0);
        chk("wrap.first", dout, 'h10);
        for (int i = 1; i <= 20; i++) begin
            cyc(1, 1, DW'(32'h10 + i), 1);
            chk($sformatf("wrap%0d.valid", i), vld, 1'b1);
            chk($sformatf("wrap%0d.data", i), dout, 32'h10 + i);
`ifdef STATE_DELAY_FIFO_COUNT_EN
            chk($sformatf("wrap%0d.count", i), cnt, 1);
`endif
        end
        cyc(1, 0, 'h00, 1);
        check_model("drain");

        // Asynchronous reset with three vectors resident and a push pending.
        cyc(1, 1, 'hA1, 0);
        cyc(1, 1, 'hA2, 0);
        cyc(1, 1, 'hA3, 0);
        check_model("pre_rst");
        vin = 1'b1;
        din = 'hA4;
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst.ready", rdy, 1'b0);
        chk("async_rst.valid", vld, 1'b0);
`ifdef STATE_DELAY_FIFO_COUNT_EN
        chk("async_rst.count", cnt, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        vin = 1'b0;
        cyc(1, 0, 'h00, 0);
        chk("post_rst.ready", rdy, 1'b1);
        chk("post_rst.valid", vld, 1'b0);
        check_model("post_rst");

        // Random traffic against the queue model, mostly training with occasional inference.
        for (int i = 0; i < 400; i++) begin
            rd = DW'({$urandom, $urandom});
            cyc($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, rd,
                $urandom_range(0, 2) == 0);
            check_model($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
